processing_hw_mul_pipe: RTL

Parametrised pipelined multiplier / multiply-accumulate for the Processing_HW datapath. It is the generalised successor of the fixed 12x13 unsigned DSP48 multipliers.
- Configurable operand widths, per-operand signedness and pipeline depth.
- Valid tracking through the pipe, plus an optional running-sum (accumulate) mode.
- Targets DSP48 inference; sits between HLS-generated datapath stages under a global ce stall.

---
 rtl/processing_hw_mul_pkg.sv | 37 +++
 rtl/processing_hw_mul_shreg.sv | 40 ++++
 rtl/processing_hw_mul_pipe.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/processing_hw_mul_pkg.sv
// Shared types and helpers for the Processing_HW pipelined multiplier / MAC.
// Optional saturation build: PROCESSING_HW_MUL_SAT_EN.
package processing_hw_mul_pkg;

    typedef struct packed {
        logic valid;
        logic acc_en;
        logic acc_clr;
    } sideband_t;

    localparam int SB_WIDTH       = $bits(sideband_t);
    localparam int MAX_DOUT_WIDTH = 128;

    function automatic int prod_width(input int a, input int b);
        return a + b;
    endfunction

    // Legal configuration: result wide enough for the full product, at least two stages.
    function automatic bit cfg_ok(input int dout_w, input int pw, input int stages);
        return (dout_w >= pw) && (dout_w <= MAX_DOUT_WIDTH) && (stages >= 2);
    endfunction

    function automatic logic [127:0] sat_max(input int w, input bit is_signed);
        if (is_signed)
            return (128'(1) << (w - 1)) - 128'(1);
        else
            return (128'(1) << w) - 128'(1);
    endfunction

    function automatic logic [127:0] sat_min(input int w, input bit is_signed);
        if (is_signed)
            return 128'(1) << (w - 1);
        else
            return '0;
    endfunction

endpackage

// File: rtl/processing_hw_mul_shreg.sv
// Clock-enabled delay line with asynchronous reset; DEPTH=0 is a pass-through.
module processing_hw_mul_shreg #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_line
            logic [WIDTH-1:0] line_q [DEPTH];
            logic [WIDTH-1:0] line_d [DEPTH];

            always_comb begin
                for (int i = 0; i < DEPTH; i++) line_d[i] = line_q[i];
                if (ce) begin
                    line_d[0] = din;
                    for (int i = 1; i < DEPTH; i++) line_d[i] = line_q[i-1];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
                end else begin
                    for (int i = 0; i < DEPTH; i++) line_q[i] <= line_d[i];
                end
            end

            assign dout = line_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/processing_hw_mul_pipe.sv
// Parametrised pipelined multiplier / multiply-accumulate with valid tracking under ce.
// Define PROCESSING_HW_MUL_SAT_EN for a saturating accumulate with sticky ovf.
module processing_hw_mul_pipe
    import processing_hw_mul_pkg::*;
#(
    parameter int DIN0_WIDTH  = 12,
    parameter int DIN1_WIDTH  = 13,
    parameter int DOUT_WIDTH  = 25,
    parameter int NUM_STAGE   = 4,
    parameter int DIN0_SIGNED = 0,
    parameter int DIN1_SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  acc_en,
    input  logic                  acc_clr,
    output logic                  out_valid,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam int PW      = prod_width(DIN0_WIDTH, DIN1_WIDTH);
    localparam bit PSIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);
    localparam bit CFG_OK  = cfg_ok(DOUT_WIDTH, PW, NUM_STAGE);

    generate
        if (!CFG_OK) begin : g_bad_cfg
            $error("processing_hw_mul_pipe: illegal DOUT_WIDTH/NUM_STAGE configuration");
        end
    endgenerate

    logic [DIN0_WIDTH-1:0] a_q, a_d;
    logic [DIN1_WIDTH-1:0] b_q, b_d;

    always_comb begin
        a_d = ce ? din0 : a_q;
        b_d = ce ? din1 : b_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    // Sideband rides alongside: stage 1 plus the NUM_STAGE-2 retiming stages.
    sideband_t             sb_in, sb_r;
    logic [SB_WIDTH-1:0]   sb_line;

    always_comb sb_in = '{valid: in_valid, acc_en: acc_en, acc_clr: acc_clr};

    processing_hw_mul_shreg #(.DEPTH(NUM_STAGE - 1), .WIDTH(SB_WIDTH)) u_sb_line (
        .clk(clk), .reset(reset), .ce(ce), .din(sb_in), .dout(sb_line)
    );

    assign sb_r = sb_line;

    // One guard bit per operand lets a single signed multiply cover every signedness mix.
    logic signed [DIN0_WIDTH:0] a_ext;
    logic signed [DIN1_WIDTH:0] b_ext;
    logic signed [PW-1:0]       prod_full;
    logic [PW-1:0]              prod_r;
    logic signed [PW-1:0]       prod_s;
    logic [DOUT_WIDTH-1:0]      prod_ext;

    always_comb begin
        a_ext     = {((DIN0_SIGNED != 0) ? a_q[DIN0_WIDTH-1] : 1'b0), a_q};
        b_ext     = {((DIN1_SIGNED != 0) ? b_q[DIN1_WIDTH-1] : 1'b0), b_q};
        prod_full = PW'(a_ext) * PW'(b_ext);
    end

    processing_hw_mul_shreg #(.DEPTH(NUM_STAGE - 2), .WIDTH(PW)) u_prod_line (
        .clk(clk), .reset(reset), .ce(ce), .din(prod_full), .dout(prod_r)
    );

    assign prod_s = prod_r;

    always_comb begin
        if (PSIGNED) prod_ext = DOUT_WIDTH'(prod_s);
        else         prod_ext = DOUT_WIDTH'(prod_r);
    end

    logic [DOUT_WIDTH-1:0] dout_q, dout_d;
    logic                  out_valid_q, out_valid_d;
    logic                  ovf_q, ovf_d;
    logic [DOUT_WIDTH-1:0] acc_sum;
    logic                  sum_ovf;

`ifdef PROCESSING_HW_MUL_SAT_EN
    localparam logic [127:0] SAT_MAX_W = sat_max(DOUT_WIDTH, PSIGNED);
    localparam logic [127:0] SAT_MIN_W = sat_min(DOUT_WIDTH, PSIGNED);
    localparam logic [DOUT_WIDTH-1:0] SAT_MAX = SAT_MAX_W[DOUT_WIDTH-1:0];
    localparam logic [DOUT_WIDTH-1:0] SAT_MIN = SAT_MIN_W[DOUT_WIDTH-1:0];

    logic [DOUT_WIDTH:0] sum_c;

    always_comb begin
        sum_c = {1'b0, dout_q} + {1'b0, prod_ext};
        if (PSIGNED)
            sum_ovf = (dout_q[DOUT_WIDTH-1] == prod_ext[DOUT_WIDTH-1]) &&
                      (sum_c[DOUT_WIDTH-1] != dout_q[DOUT_WIDTH-1]);
        else
            sum_ovf = sum_c[DOUT_WIDTH];
        if (!sum_ovf)
            acc_sum = sum_c[DOUT_WIDTH-1:0];
        else if (PSIGNED && dout_q[DOUT_WIDTH-1])
            acc_sum = SAT_MIN;
        else
            acc_sum = SAT_MAX;
    end
`else
    always_comb begin
        acc_sum = dout_q + prod_ext;
        sum_ovf = 1'b0;
    end
`endif

    // Bubbles leave dout untouched so a running sum survives gaps in the beat stream.
    always_comb begin
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        if (ce) begin
            out_valid_d = sb_r.valid;
            if (sb_r.valid) begin
                if (!sb_r.acc_en) begin
                    dout_d = prod_ext;
                end else if (sb_r.acc_clr) begin
                    dout_d = prod_ext;
                    ovf_d  = 1'b0;
                end else begin
                    dout_d = acc_sum;
                    ovf_d  = ovf_q | sum_ovf;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign dout      = dout_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;

endmodule
